// File: rtl/otter_pkg.sv
// Shared OTTER types: RV32I opcodes (shared with the decoder), control-unit
// states and the SYSTEM func3 codes the control unit distinguishes.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP_RG3 = 7'b0110011,
        SYS    = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } cu_state_t;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: synchronous active-low clear, increment enable,
// silent wrap-around at 2^W.
module instret_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/cu_fsm.sv
// OTTER multi-cycle control-unit FSM: FETCH/EXEC/(WB)/(INTR) sequencing and enables.
// Interrupt handling is built only when CU_FSM_INTR_EN is defined.
module cu_fsm
    import otter_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 intr,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    output logic                 pc_rst,
    output logic                 pcWrite,
    output logic                 regWrite,
    output logic                 memWE2,
    output logic                 memRDEN1,
    output logic                 memRDEN2,
    output logic                 csr_WE,
    output logic                 mret_exec,
    output logic                 int_taken,
    output logic [INSTRET_W-1:0] instret
);

    cu_state_t state, state_nxt;
    opcode_t   op;
    logic      intr_req;
    logic      int_taken_c;
    logic      instret_en;

    assign op = opcode_t'(opcode);

`ifdef CU_FSM_INTR_EN
    logic intr_pend;

    assign intr_req  = intr | intr_pend;
    assign int_taken = int_taken_c;

    // Entering ST_INTR consumes the request, even if intr is high on that edge.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            intr_pend <= 1'b0;
        else if (state_nxt == ST_INTR)
            intr_pend <= 1'b0;
        else if (intr)
            intr_pend <= 1'b1;
    end
`else
    logic unused_intr;

    assign unused_intr = intr ^ int_taken_c;
    assign intr_req    = 1'b0;
    assign int_taken   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    // A load never yields to an interrupt between EXEC and WB.
    always_comb begin
        state_nxt = ST_INIT;
        case (state)
            ST_INIT:  state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (op == LOAD)
                    state_nxt = ST_WB;
                else if (intr_req)
                    state_nxt = ST_INTR;
                else
                    state_nxt = ST_FETCH;
            end
            ST_WB:    state_nxt = intr_req ? ST_INTR : ST_FETCH;
            ST_INTR:  state_nxt = ST_FETCH;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        pc_rst      = 1'b0;
        pcWrite     = 1'b0;
        regWrite    = 1'b0;
        memWE2      = 1'b0;
        memRDEN1    = 1'b0;
        memRDEN2    = 1'b0;
        csr_WE      = 1'b0;
        mret_exec   = 1'b0;
        int_taken_c = 1'b0;
        case (state)
            ST_INIT:  pc_rst   = 1'b1;
            ST_FETCH: memRDEN1 = 1'b1;
            ST_EXEC: begin
                case (op)
                    LUI, AUIPC, OP_IMM, OP_RG3, JAL, JALR: begin
                        pcWrite  = 1'b1;
                        regWrite = 1'b1;
                    end
                    BRANCH: pcWrite = 1'b1;
                    STORE: begin
                        pcWrite = 1'b1;
                        memWE2  = 1'b1;
                    end
                    LOAD: memRDEN2 = 1'b1;
                    SYS: begin
                        pcWrite = 1'b1;
                        if (func3 == F3_MRET) begin
                            mret_exec = 1'b1;
                        end else if (func3 == F3_CSRRW) begin
                            regWrite = 1'b1;
                            csr_WE   = 1'b1;
                        end
                    end
                    // Unknown opcodes retire as NOPs so the PC still advances.
                    default: pcWrite = 1'b1;
                endcase
            end
            ST_WB: begin
                pcWrite  = 1'b1;
                regWrite = 1'b1;
            end
            ST_INTR: begin
                pcWrite     = 1'b1;
                int_taken_c = 1'b1;
            end
            default: ;
        endcase
    end

    // The MTVEC load in ST_INTR moves the PC but retires nothing.
    assign instret_en = pcWrite && (state != ST_INTR);

    instret_counter #(
        .W(INSTRET_W)
    ) u_instret (
        .clk   (CLK),
        .clr_n (RST_N),
        .en    (instret_en),
        .count (instret)
    );

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_cu_fsm;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_OPI = 7'b0010011, O_OPR = 7'b0110011;
    localparam logic [6:0] O_SYS = 7'b1110011, O_BAD = 7'b1111111;

    // {pc_rst,pcWrite,regWrite,memWE2,memRDEN1,memRDEN2,csr_WE,mret_exec,int_taken}
    localparam logic [8:0] V_INIT = 9'h100, V_FETCH = 9'h010, V_PWRW = 9'h0C0;
    localparam logic [8:0] V_PW = 9'h080, V_ST = 9'h0A0, V_LD = 9'h008;
    localparam logic [8:0] V_MRET = 9'h082, V_CSR = 9'h0C4, V_WB = 9'h0C0, V_INTR = 9'h081;

`ifdef CU_FSM_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, intr = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic        pc_rst, pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
    logic        csr_WE, mret_exec, int_taken;
    logic [31:0] instret;
    logic [8:0]  obs;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_instret = '0;
    bit          m_pend = 1'b0;

    assign obs = {pc_rst, pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, mret_exec, int_taken};

    always #5 clk = ~clk;

    cu_fsm #(.INSTRET_W(32)) dut (
        .CLK(clk), .RST_N(rst_n), .intr(intr), .opcode(opcode), .func3(func3),
        .pc_rst(pc_rst), .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2),
        .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .csr_WE(csr_WE),
        .mret_exec(mret_exec), .int_taken(int_taken), .instret(instret)
    );

    function automatic logic [8:0] exec_exp(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            O_LUI, O_AUIPC, O_OPI, O_OPR, O_JAL, O_JALR: return V_PWRW;
            O_BR:  return V_PW;
            O_ST:  return V_ST;
            O_LD:  return V_LD;
            O_SYS: return (f3 == 3'b000) ? V_MRET : (f3 == 3'b001) ? V_CSR : V_PW;
            default: return V_PW;
        endcase
    endfunction

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); #4; endtask

    task automatic test_reset();
        nxt(); nxt(); smp();
        n_chk++; if (obs !== V_INIT) begin n_fail++; $display("FAIL reset_outs: got %b want %b", obs, V_INIT); end
        n_chk++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
        nxt(); rst_n = 1'b1;
    endtask

    task automatic test_opimm();
        smp();
        n_chk++; if (obs !== V_INIT) begin n_fail++; $display("FAIL opimm_init: got %b want %b", obs, V_INIT); end
        nxt(); opcode = O_OPI; smp();
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL opimm_fetch: got %b want %b", obs, V_FETCH); end
        nxt(); smp();
        n_chk++; if (obs !== V_PWRW) begin n_fail++; $display("FAIL opimm_exec: got %b want %b", obs, V_PWRW); end
        nxt(); m_instret = 32'd1;
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL opimm_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_load();
        opcode = O_LD; smp();
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL load_fetch: got %b want %b", obs, V_FETCH); end
        nxt(); smp();
        n_chk++; if (obs !== V_LD) begin n_fail++; $display("FAIL load_exec: got %b want %b", obs, V_LD); end
        nxt(); smp();
        n_chk++; if (obs !== V_WB) begin n_fail++; $display("FAIL load_wb: got %b want %b", obs, V_WB); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL load_wb_instret: got %0d want %0d", instret, m_instret); end
        nxt(); m_instret++;
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL load_ret: got %b want %b", obs, V_FETCH); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL load_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_store_branch();
        opcode = O_ST; nxt(); smp();
        n_chk++; if (obs !== V_ST) begin n_fail++; $display("FAIL store_exec: got %b want %b", obs, V_ST); end
        nxt(); m_instret++; opcode = O_BR; nxt(); smp();
        n_chk++; if (obs !== V_PW) begin n_fail++; $display("FAIL branch_exec: got %b want %b", obs, V_PW); end
        nxt(); m_instret++;
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL stbr_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_sys();
        logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b110};
        logic [8:0] exps [3] = '{V_MRET, V_CSR, V_PW};
        for (int i = 0; i < 3; i++) begin
            opcode = O_SYS; func3 = f3s[i]; nxt(); smp();
            n_chk++; if (obs !== exps[i]) begin n_fail++; $display("FAIL sys_f3_%0d: got %b want %b", f3s[i], obs, exps[i]); end
            nxt(); m_instret++;
        end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL sys_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_intr();
        opcode = O_LD; intr = 1'b1; smp();
        nxt(); intr = 1'b0; smp();
        n_chk++; if (obs !== V_LD) begin n_fail++; $display("FAIL intr_ld_exec: got %b want %b", obs, V_LD); end
        nxt(); smp();
        n_chk++; if (obs !== V_WB) begin n_fail++; $display("FAIL intr_ld_wb: got %b want %b", obs, V_WB); end
        nxt(); m_instret++;
        n_chk++; if (obs !== (INTR_EN ? V_INTR : V_FETCH)) begin n_fail++; $display("FAIL intr_entry: got %b want %b", obs, INTR_EN ? V_INTR : V_FETCH); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL intr_entry_instret: got %0d want %0d", instret, m_instret); end
        if (INTR_EN) nxt();
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL intr_exit: got %b want %b", obs, V_FETCH); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL intr_exit_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_reset_mid_load();
        opcode = O_LD; intr = 1'b1; nxt(); intr = 1'b0; nxt();
        rst_n = 1'b0; smp();
        n_chk++; if (obs !== V_WB) begin n_fail++; $display("FAIL rstwb_wb: got %b want %b", obs, V_WB); end
        nxt(); rst_n = 1'b1; m_instret = '0; m_pend = 1'b0;
        n_chk++; if (obs !== V_INIT) begin n_fail++; $display("FAIL rstwb_init: got %b want %b", obs, V_INIT); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL rstwb_instret: got %0d want 0", instret); end
        nxt(); opcode = O_OPI;
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL rstwb_fetch: got %b want %b", obs, V_FETCH); end
        nxt(); smp();
        n_chk++; if (obs !== V_PWRW) begin n_fail++; $display("FAIL rstwb_exec: got %b want %b", obs, V_PWRW); end
        nxt(); m_instret = 32'd1;
        n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL rstwb_pend_cleared: got %b want %b", obs, V_FETCH); end
        n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL rstwb_instret2: got %0d want %0d", instret, m_instret); end
    endtask

    // Instruction-level model: each instruction is FETCH, EXEC, WB for loads,
    // then an interrupt slot if a request was seen before the retiring edge.
    task automatic test_random();
        logic [6:0] ops [11] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OPR, O_SYS, O_BAD};
        logic [6:0] op;
        logic [2:0] f3;
        logic [8:0] e;
        bit         iv;
        for (int n = 0; n < 120; n++) begin
            op = ops[$urandom_range(0, 10)];
            f3 = 3'($urandom_range(0, 7));
            opcode = 7'($urandom); func3 = 3'($urandom);
            iv = ($urandom_range(0, 4) == 0); intr = iv; smp();
            n_chk++; if (obs !== V_FETCH) begin n_fail++; $display("FAIL rnd%0d_fetch: got %b want %b", n, obs, V_FETCH); end
            n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL rnd%0d_instret: got %0d want %0d", n, instret, m_instret); end
            nxt(); m_pend = m_pend | (iv & INTR_EN);
            opcode = op; func3 = f3; e = exec_exp(op, f3);
            iv = ($urandom_range(0, 4) == 0); intr = iv; smp();
            n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rnd%0d_exec op=%b f3=%b: got %b want %b", n, op, f3, obs, e); end
            nxt(); if (e[7]) m_instret++;
            if (op == O_LD) begin
                m_pend = m_pend | (iv & INTR_EN);
                opcode = 7'($urandom); iv = ($urandom_range(0, 4) == 0); intr = iv; smp();
                n_chk++; if (obs !== V_WB) begin n_fail++; $display("FAIL rnd%0d_wb: got %b want %b", n, obs, V_WB); end
                nxt(); m_instret++;
            end
            if (INTR_EN && (m_pend || iv)) begin
                m_pend = 1'b0;
                iv = ($urandom_range(0, 2) == 0); intr = iv; smp();
                n_chk++; if (obs !== V_INTR) begin n_fail++; $display("FAIL rnd%0d_intr: got %b want %b", n, obs, V_INTR); end
                n_chk++; if (instret !== m_instret) begin n_fail++; $display("FAIL rnd%0d_intr_instret: got %0d want %0d", n, instret, m_instret); end
                nxt(); m_pend = iv;
            end
        end
        intr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_load();
        test_store_branch();
        test_sys();
        test_intr();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
